// File: rtl/regfile_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_sb_pkg
//
// Shared definitions for the decode-stage register file and its read ports:
// default geometry, the hardwired-zero register index, and the index/data
// word types.
// ----------------------------------------------------------------------------
package regfile_sb_pkg;

    // Default geometry: 32 x 32-bit registers.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    // Register 0 always reads as zero and can never be marked busy.
    localparam int REG_ZERO = 0;

    // Register index and data word at the default geometry.
    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_word_t;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_rdport.sv
// ----------------------------------------------------------------------------
// regfile_sb_rdport
//
// One combinational read port of regfile_sb. It selects the operand word and
// the operand busy flag for a single read address.
//
// The operand comes from one of three places:
//   - register 0: constant zero;
//   - the writeback port, when it targets the same register this cycle
//     (bypass);
//   - otherwise the storage array.
//
// The busy flag is the scoreboard bit of the addressed register. It is masked
// when writeback delivers that register in the same cycle, because the
// bypassed value is already the producer's result.
//
// Ports
//   i_raddr   read address
//   i_wen     writeback write enable
//   i_waddr   writeback destination
//   i_wdata   writeback data
//   i_rf      storage array contents
//   i_busy    scoreboard busy vector
//   o_rdata   operand data
//   o_rbusy   operand still pending (hazard)
// ----------------------------------------------------------------------------
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rf [DEPTH],
    input  logic [DEPTH-1:0]      i_busy,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rbusy
);

    logic w_is_zero;
    logic w_wr_hit;

    assign w_is_zero = (i_raddr == ADDR_WIDTH'(REG_ZERO));

    // The writeback port targets the register being read in this cycle.
    assign w_wr_hit  = i_wen && (i_waddr == i_raddr);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves it unassigned would infer a latch.
        o_rdata = i_rf[i_raddr];
        if (w_is_zero) begin
            o_rdata = '0;
        end else if (w_wr_hit) begin
            o_rdata = i_wdata;
        end
    end

    // Register 0 never holds a busy bit, so it never reports busy here either;
    // the explicit zero term keeps that independent of the scoreboard.
    assign o_rbusy = i_busy[i_raddr] && !w_wr_hit && !w_is_zero;

endmodule : regfile_sb_rdport

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//
// Decode-stage general-purpose register file for the five-stage pipeline. It
// provides NUM_READ combinational read ports, one writeback write port, and an
// integrated busy-bit scoreboard. The hazard logic uses the per-port busy
// flags to stall on outstanding producers such as loads.
//
// Every register follows a two-state life cycle:
//   IDLE -> (issue sets busy)           -> BUSY
//   BUSY -> (writeback or flush clears) -> IDLE
//
// Register 0 is hardwired to zero:
//   - writes to it are dropped;
//   - issue cannot mark it busy;
//   - it always reads as zero and not busy.
//
// Reset asserts asynchronously: the array and the busy vector clear as soon
// as sys_rst_n falls, with no clock edge needed. Release is expected to be
// synchronised to sys_clk upstream.
//
// Parameters
//   ADDR_WIDTH  register index width (DEPTH = 2**ADDR_WIDTH)
//   DATA_WIDTH  register width
//   NUM_READ    number of read ports (1..4)
//
// Ports
//   sys_clk     pipeline clock
//   sys_rst_n   active-low reset
//   raddr       packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata       packed read data,      port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy       per-port hazard flag
//   wen/waddr/wdata        writeback port
//   set_en/set_addr        issue marks a destination busy
//   flush       clears all busy bits; an issue in the same cycle is dropped
//   any_busy    OR of all busy bits
// ----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_READ   = 2
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic                           flush,
    output logic                           any_busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // ------------------------------------------------------------------
    // State: storage array and scoreboard
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_busy_next;

    // Qualified writeback and issue requests; both are dropped for register 0.
    logic w_wr_valid;
    logic w_set_valid;

    assign w_wr_valid  = wen    && (waddr    != ADDR_WIDTH'(REG_ZERO));
    assign w_set_valid = set_en && (set_addr != ADDR_WIDTH'(REG_ZERO));

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array is cleared by reset because the pipeline relies on
    // every register reading zero after reset. This keeps it in flops rather
    // than letting it map onto a RAM macro.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_valid) begin
            // NOTE: state registers take non-blocking assignments so every
            // flop samples its inputs as they were before the edge.
            r_rf[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Priority, highest first:
    //   1. flush clears everything and drops any same-cycle issue;
    //   2. otherwise writeback clears its destination;
    //   3. then issue sets its destination.
    // The set is applied after the clear, so when both hit the same register
    // the new producer wins and the bit stays set.
    always_comb begin
        w_busy_next = r_busy;
        if (flush) begin
            w_busy_next = '0;
        end else begin
            if (w_wr_valid) begin
                w_busy_next[waddr] = 1'b0;
            end
            if (w_set_valid) begin
                w_busy_next[set_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign any_busy = |r_busy;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_READ; g++) begin : g_rdport
        regfile_sb_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_rdport (
            .i_raddr (raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_wen   (wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .i_rf    (r_rf),
            .i_busy  (r_busy),
            .o_rdata (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_rbusy (rbusy[g])
        );
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//
// Directed bench for regfile_sb at its default geometry (32 x 32, two read
// ports).
//
// Timing of each cycle:
//   - stimulus changes the inputs 1 ns after the rising edge;
//   - in the same step it queues the outputs it expects for that cycle;
//   - a monitor drains the queue on the falling edge and compares.
// ----------------------------------------------------------------------------
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int NR = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              wen;
    reg_idx_t          waddr;
    data_word_t        wdata;
    logic              set_en;
    reg_idx_t          set_addr;
    logic              flush;
    logic              any_busy;

    typedef enum {K_DATA, K_BUSY, K_ANY} kind_e;

    typedef struct {
        string      name;
        kind_e      kind;
        int         port;
        data_word_t val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    regfile_sb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_READ   (NR)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .set_en    (set_en),
        .set_addr  (set_addr),
        .flush     (flush),
        .any_busy  (any_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // ------------------------------------------------------------------
    // Monitor: compares every queued expectation against the live outputs
    // ------------------------------------------------------------------
    always @(negedge sys_clk) begin
        while (sb_q.size() > 0) begin
            exp_t       e;
            data_word_t act;
            e = sb_q.pop_front();
            case (e.kind)
                K_DATA:  act = rdata[e.port*DW +: DW];
                K_BUSY:  act = {31'd0, rbusy[e.port]};
                default: act = {31'd0, any_busy};
            endcase
            n_vec++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input string n, input kind_e k, input int p, input data_word_t v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.port = p;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_d(input string n, input int p, input data_word_t v);
        push(n, K_DATA, p, v);
    endtask

    task automatic exp_b(input string n, input int p, input logic b);
        push(n, K_BUSY, p, {31'd0, b});
    endtask

    task automatic exp_a(input string n, input logic b);
        push(n, K_ANY, 0, {31'd0, b});
    endtask

    // Move to the next cycle; write and issue requests default to idle.
    task automatic step();
        @(posedge sys_clk);
        #1;
        wen    = 1'b0;
        set_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic rd(input int p, input reg_idx_t a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic wr(input reg_idx_t a, input data_word_t d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    task automatic setb(input reg_idx_t a);
        set_en   = 1'b1;
        set_addr = a;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    initial begin
        sys_rst_n = 1'b0;
        raddr     = '0;
        wen       = 1'b0;
        waddr     = '0;
        wdata     = '0;
        set_en    = 1'b0;
        set_addr  = '0;
        flush     = 1'b0;

        // Outputs while reset is held.
        step();
        rd(0, 5'd1); rd(1, 5'd31);
        exp_d("rst_rd0_r1", 0, 32'h0);
        exp_d("rst_rd1_r31", 1, 32'h0);
        exp_b("rst_busy0", 0, 1'b0);
        exp_b("rst_busy1", 1, 1'b0);
        exp_a("rst_any", 1'b0);

        // Release, then read again.
        step();
        sys_rst_n = 1'b1;
        step();
        exp_d("post_rst_rd0", 0, 32'h0);
        exp_d("post_rst_rd1", 1, 32'h0);
        exp_a("post_rst_any", 1'b0);

        // Write reg 5: visible through the bypass in the same cycle.
        step();
        wr(5'd5, 32'hDEADBEEF);
        rd(0, 5'd5); rd(1, 5'd0);
        exp_d("bypass_r5", 0, 32'hDEADBEEF);
        exp_b("bypass_r5_busy", 0, 1'b0);
        exp_d("r0_during_wr", 1, 32'h0);

        // Next cycle the value comes from the array; reg 5 never became busy.
        step();
        exp_d("array_r5", 0, 32'hDEADBEEF);
        exp_a("wr_nonbusy_any", 1'b0);

        // Writes to register 0 are dropped, and it never bypasses.
        step();
        wr(5'd0, 32'h12345678);
        rd(0, 5'd0); rd(1, 5'd0);
        exp_d("r0_nobypass", 1, 32'h0);
        step();
        setb(5'd0);
        exp_d("r0_array", 1, 32'h0);
        step();
        exp_a("set_r0_any", 1'b0);
        exp_b("set_r0_busy", 1, 1'b0);

        // Busy life cycle of reg 7: set at k, busy from k+1, written at k+3.
        step();
        setb(5'd7);
        rd(0, 5'd7);
        exp_b("r7_k", 0, 1'b0);
        exp_a("r7_k_any", 1'b0);
        step();
        exp_b("r7_k1", 0, 1'b1);
        exp_a("r7_k1_any", 1'b1);
        step();
        exp_b("r7_k2", 0, 1'b1);
        step();
        wr(5'd7, 32'h55);
        exp_b("r7_k3_busy", 0, 1'b0);
        exp_d("r7_k3_data", 0, 32'h55);
        exp_a("r7_k3_any", 1'b1);
        step();
        exp_b("r7_k4_busy", 0, 1'b0);
        exp_d("r7_k4_data", 0, 32'h55);
        exp_a("r7_k4_any", 1'b0);

        // Reg 9: a same-cycle write and re-issue leaves it busy.
        step();
        setb(5'd9);
        rd(0, 5'd9);
        step();
        exp_b("r9_busy", 0, 1'b1);
        step();
        wr(5'd9, 32'h99);
        setb(5'd9);
        exp_b("r9_wrset_busy", 0, 1'b0);
        exp_d("r9_wrset_data", 0, 32'h99);
        step();
        exp_b("r9_reset_busy", 0, 1'b1);
        exp_d("r9_array", 0, 32'h99);

        // Flush together with a set: everything ends up idle.
        step();
        setb(5'd3);
        step();
        setb(5'd4);
        step();
        setb(5'd6);
        step();
        rd(0, 5'd3); rd(1, 5'd4);
        exp_b("r3_busy", 0, 1'b1);
        exp_b("r4_busy", 1, 1'b1);
        step();
        flush = 1'b1;
        setb(5'd8);
        rd(0, 5'd6); rd(1, 5'd8);
        exp_b("flush_cyc_r6", 0, 1'b1);
        exp_b("flush_cyc_r8", 1, 1'b0);
        step();
        rd(0, 5'd3); rd(1, 5'd4);
        exp_a("post_flush_any", 1'b0);
        exp_b("post_flush_r3", 0, 1'b0);
        exp_b("post_flush_r4", 1, 1'b0);
        step();
        rd(0, 5'd6); rd(1, 5'd8);
        exp_b("post_flush_r6", 0, 1'b0);
        exp_b("post_flush_r8", 1, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        step();
        wr(5'd10, 32'hA5A5A5A5);
        setb(5'd11);
        step();
        rd(0, 5'd10); rd(1, 5'd11);
        exp_d("pre_arst_r10", 0, 32'hA5A5A5A5);
        exp_b("pre_arst_r11", 1, 1'b1);
        exp_a("pre_arst_any", 1'b1);
        step();
        // This write is pending when reset hits, so it must be lost.
        wr(5'd12, 32'hCAFEF00D);
        #2;
        sys_rst_n = 1'b0;
        exp_d("arst_r10", 0, 32'h0);
        exp_b("arst_r11", 1, 1'b0);
        exp_a("arst_any", 1'b0);
        step();
        sys_rst_n = 1'b1;
        step();
        rd(0, 5'd5); rd(1, 5'd12);
        exp_d("arst_r5_cleared", 0, 32'h0);
        exp_d("arst_lost_wr12", 1, 32'h0);

        // Let the monitor drain the final cycle.
        @(negedge sys_clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad += sb_q.size();
            $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_regfile_sb
